// File: rtl/lbm_bram_pkg.sv
// lbm_bram_pkg: shared defaults, D2Q9 direction indices and arbiter FSM encoding
package lbm_bram_pkg;
  localparam int NCH_D = 9;
  localparam int DW_D = 32;
  localparam int AW_D = 12;
  localparam int DIR_NULL = 0;
  localparam int DIR_N = 1;
  localparam int DIR_NE = 2;
  localparam int DIR_E = 3;
  localparam int DIR_SE = 4;
  localparam int DIR_S = 5;
  localparam int DIR_SW = 6;
  localparam int DIR_W = 7;
  localparam int DIR_NW = 8;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SWAP   = 2'd3
  } state_t;
endpackage

// File: rtl/bram_pingpong_arbiter_rd_valid_delay.sv
// rd_valid_delay: fixed-depth shift of a read-valid flag together with the bank it targeted
module rd_valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic m00_axis_aclk,
  input  logic m00_axis_areset,
  input  logic vin,
  input  logic tin,
  output logic vout,
  output logic tout
);
  logic [DEPTH-1:0] v_q, t_q;
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      v_q <= '0;
      t_q <= '0;
    end else begin
      v_q <= {v_q[DEPTH-2:0], vin};
      t_q <= {t_q[DEPTH-2:0], tin};
    end
  end
  assign vout = v_q[DEPTH-1];
  assign tout = t_q[DEPTH-1];
endmodule

// File: rtl/bram_pingpong_arbiter.sv
// bram_pingpong_arbiter: routes solver and DDR-cache ports onto two ping-pong BRAM banks
module bram_pingpong_arbiter
  import lbm_bram_pkg::*;
#(
  parameter int NCH = NCH_D,
  parameter int DW = DW_D,
  parameter int AW = AW_D,
  parameter int RD_LAT = 1
) (
  input  logic              m00_axis_aclk,
  input  logic              m00_axis_areset,
  input  logic              start,
  input  logic              cache_phase_done,
  input  logic              lbm_phase_done,
  input  logic [NCH*AW-1:0] lbm_addr,
  input  logic [NCH-1:0]    lbm_wen,
  input  logic              lbm_ren,
  input  logic [NCH*DW-1:0] lbm_wdata,
  output logic [NCH*DW-1:0] lbm_rdata,
  output logic              lbm_rvalid,
  input  logic [AW-1:0]     cache_addr,
  input  logic              cache_wen,
  input  logic              cache_ren,
  input  logic [NCH*DW-1:0] cache_wdata,
  output logic [NCH*DW-1:0] cache_rdata,
  output logic              cache_rvalid,
  output logic [NCH*AW-1:0] bank0_addr,
  output logic [NCH-1:0]    bank0_wen,
  output logic [NCH*DW-1:0] bank0_wdata,
  input  logic [NCH*DW-1:0] bank0_rdata,
  output logic [NCH*AW-1:0] bank1_addr,
  output logic [NCH-1:0]    bank1_wen,
  output logic [NCH*DW-1:0] bank1_wdata,
  input  logic [NCH*DW-1:0] bank1_rdata,
  output logic              bank_sel,
  output logic              swap_pulse,
  output logic              busy,
  output logic              protocol_err
);
  state_t state, state_nxt;
  logic [2:0] drain_cnt;
  logic lbm_done_q, cache_done_q, active, lbm_set, cache_set;
  logic lbm_rv, lbm_rt, cache_rv, cache_rt;
  logic [NCH*AW-1:0] addr_q [2];
  logic [NCH-1:0] wen_q [2];
  logic [NCH*DW-1:0] wdata_q [2];
  assign active = state == ST_ACTIVE;
  assign lbm_set = lbm_done_q | (active & lbm_phase_done);
  assign cache_set = cache_done_q | (active & cache_phase_done);
  always_comb begin
    state_nxt = state == ST_IDLE   ? (start ? ST_ACTIVE : ST_IDLE)
              : state == ST_ACTIVE ? (lbm_set && cache_set ? ST_DRAIN : ST_ACTIVE)
              : state == ST_DRAIN  ? (drain_cnt == 3'(RD_LAT) ? ST_SWAP : ST_DRAIN)
              : ST_ACTIVE;
  end
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state <= ST_IDLE;
      drain_cnt <= '0;
      bank_sel <= 1'b0;
      lbm_done_q <= 1'b0;
      cache_done_q <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nxt;
      drain_cnt <= state == ST_DRAIN ? drain_cnt + 3'd1 : 3'd0;
      bank_sel <= bank_sel ^ (state == ST_DRAIN && state_nxt == ST_SWAP);
      lbm_done_q <= (state_nxt != ST_SWAP) & lbm_set;
      cache_done_q <= (state_nxt != ST_SWAP) & cache_set;
      protocol_err <= protocol_err | (lbm_phase_done & (!active | lbm_done_q))
                                   | (cache_phase_done & (!active | cache_done_q));
    end
  end
  // Bank pins are registered; writes only reach a bank while ACTIVE
  always_ff @(posedge m00_axis_aclk) begin
    for (int k = 0; k < 2; k++) begin
      if (m00_axis_areset) begin
        addr_q[k] <= '0;
        wen_q[k] <= '0;
        wdata_q[k] <= '0;
      end else begin
        addr_q[k] <= bank_sel == k[0] ? lbm_addr : {NCH{cache_addr}};
        wen_q[k] <= !active ? '0 : bank_sel == k[0] ? lbm_wen : {NCH{cache_wen}};
        wdata_q[k] <= bank_sel == k[0] ? lbm_wdata : cache_wdata;
      end
    end
  end
  assign bank0_addr = addr_q[0];
  assign bank0_wen = wen_q[0];
  assign bank0_wdata = wdata_q[0];
  assign bank1_addr = addr_q[1];
  assign bank1_wen = wen_q[1];
  assign bank1_wdata = wdata_q[1];
  rd_valid_delay #(.DEPTH(RD_LAT + 1)) u_lbm_rd (
    .m00_axis_aclk(m00_axis_aclk),
    .m00_axis_areset(m00_axis_areset),
    .vin(active & lbm_ren),
    .tin(bank_sel),
    .vout(lbm_rv),
    .tout(lbm_rt)
  );
  rd_valid_delay #(.DEPTH(RD_LAT + 1)) u_cache_rd (
    .m00_axis_aclk(m00_axis_aclk),
    .m00_axis_areset(m00_axis_areset),
    .vin(active & cache_ren),
    .tin(~bank_sel),
    .vout(cache_rv),
    .tout(cache_rt)
  );
  assign lbm_rvalid = lbm_rv;
  assign cache_rvalid = cache_rv;
  assign lbm_rdata = lbm_rv ? (lbm_rt ? bank1_rdata : bank0_rdata) : '0;
  assign cache_rdata = cache_rv ? (cache_rt ? bank1_rdata : bank0_rdata) : '0;
  assign busy = state != ST_IDLE;
  assign swap_pulse = state == ST_SWAP;
endmodule
